// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  localparam logic PAR_EVEN        = 1'b0;
  localparam logic PAR_ODD         = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Parallel request side plus serial line of the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      DATA_VALID;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      TX_OUT;
  logic                      busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: pulses bit_done on the last cycle of every Teff-cycle bit.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      start,
  input  logic                      enable,
  output logic                      bit_done
);

  logic [PRESCALE_WIDTH-1:0] cnt;
  logic [PRESCALE_WIDTH-1:0] last_cnt;

  // Prescale of 0 and 1 both mean one cycle per bit
  assign last_cnt = (prescale <= PRESCALE_WIDTH'(1)) ? '0 : prescale - PRESCALE_WIDTH'(1);
  assign bit_done = enable && (cnt == last_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_done ? '0 : cnt + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  bus
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_tx_state_e            state, state_nxt;
  logic [DATA_WIDTH-1:0]     shift_r, shift_nxt;
  logic [BW-1:0]             bit_cnt, bit_cnt_nxt;
  logic                      tx_r, tx_nxt;
  logic                      busy_r, busy_nxt;
  logic                      par_en_r, par_bit_r;
  logic [PRESCALE_WIDTH-1:0] prescale_r;
  logic                      load;
  logic                      bit_done;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (typ == PAR_ODD) ? ~^d : ^d;
  endfunction

  uart_tx_bit_timer #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .prescale (prescale_r),
    .start    (load),
    .enable   (state != IDLE),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift_r    <= '0;
      bit_cnt    <= '0;
      tx_r       <= UART_IDLE_LEVEL;
      busy_r     <= 1'b0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      prescale_r <= '0;
    end else begin
      state   <= state_nxt;
      shift_r <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_r    <= tx_nxt;
      busy_r  <= busy_nxt;
      // Frame options are frozen at accept so mid-frame input changes are harmless
      if (load) begin
        par_en_r   <= bus.PAR_EN;
        par_bit_r  <= parity_bit(bus.P_DATA, bus.PAR_TYP);
        prescale_r <= bus.Prescale;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_r;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx_r;
    busy_nxt    = busy_r;
    load        = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.DATA_VALID) begin
          state_nxt   = START;
          shift_nxt   = bus.P_DATA;
          bit_cnt_nxt = '0;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
          load        = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt = DATA;
          tx_nxt    = shift_r[0];
          shift_nxt = shift_r >> 1;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = par_en_r ? PARITY : STOP;
            tx_nxt    = par_en_r ? par_bit_r : UART_IDLE_LEVEL;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
            tx_nxt      = shift_r[0];
            shift_nxt   = shift_r >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          tx_nxt    = UART_IDLE_LEVEL;
        end
      end
      STOP: begin
        // No accept here: guarantees one idle-high cycle between frames
        if (bit_done) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          tx_nxt    = UART_IDLE_LEVEL;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = UART_IDLE_LEVEL;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.TX_OUT = tx_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: framing, parity, busy rules, prescale edges, reset abort.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // exp holds the frame's line bits in transmit order (bit 0 = start bit)
  task automatic send_frame(input string tag, input logic [7:0] data, input logic pen,
                            input logic ptyp, input logic [5:0] ps, input int teff,
                            input int nbits, input logic [10:0] exp, input bit hold,
                            input int inject);
    int errs = 0;
    int busy_cnt = 0;
    logic [10:0] cap = '0;
    @(negedge clk);
    bus.P_DATA     = data;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = ptyp;
    bus.Prescale   = ps;
    bus.DATA_VALID = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < nbits * teff; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      if (j == 0 && !hold) bus.DATA_VALID = 1'b0;
      if (inject >= 0 && j == inject) begin
        bus.DATA_VALID = 1'b1;
        bus.P_DATA     = 8'h3C;
        bus.Prescale   = 6'd3;
        bus.PAR_EN     = ~pen;
        bus.PAR_TYP    = ~ptyp;
      end
      if (inject >= 0 && j == inject + 1) bus.DATA_VALID = 1'b0;
      if (bus.TX_OUT !== exp[j / teff]) errs++;
      if (bus.busy === 1'b1) busy_cnt++;
      if ((j % teff) == (teff / 2)) cap[j / teff] = bus.TX_OUT;
    end
    check({tag, "_bits"}, 32'(cap), 32'(exp));
    check({tag, "_hold"}, errs, 0);
    check({tag, "_busy_len"}, busy_cnt, nbits * teff);
    @(posedge clk); #1;
    check({tag, "_idle_tx"}, 32'(bus.TX_OUT), 1);
    check({tag, "_idle_busy"}, 32'(bus.busy), 0);
    if (!hold) begin
      @(posedge clk); #1;
      check({tag, "_idle2_busy"}, 32'(bus.busy), 0);
    end
  endtask

  initial begin
    int errs;
    rst            = 1'b0;
    bus.P_DATA     = 8'h45;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Prescale   = 6'd8;
    bus.DATA_VALID = 1'b1;

    // Reset held with a pending request: line stays idle
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) errs++;
    end
    check("reset_hold", errs, 0);
    @(negedge clk);
    bus.DATA_VALID = 1'b0;
    rst = 1'b1;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) errs++;
    end
    check("post_reset_idle", errs, 0);

    // 0x45, no parity: 0,1,0,1,0,0,0,1,0,1
    send_frame("p8_45", 8'h45, 1'b0, 1'b0, 6'd8, 8, 10, 11'b0_1_01000101_0, 1'b0, -1);
    // Even parity of 0xAA is 0, odd parity of 0xA8 is 0
    send_frame("even_AA", 8'hAA, 1'b1, 1'b0, 6'd8, 8, 11, 11'b1_0_10101010_0, 1'b0, -1);
    send_frame("odd_A8", 8'hA8, 1'b1, 1'b1, 6'd8, 8, 11, 11'b1_0_10101000_0, 1'b0, -1);
    send_frame("odd_01", 8'h01, 1'b1, 1'b1, 6'd8, 8, 11, 11'b1_0_00000001_0, 1'b0, -1);
    send_frame("even_01", 8'h01, 1'b1, 1'b0, 6'd8, 8, 11, 11'b1_1_00000001_0, 1'b0, -1);
    // Mid-frame request with different data/options is ignored
    send_frame("inject", 8'h45, 1'b0, 1'b0, 6'd8, 8, 10, 11'b0_1_01000101_0, 1'b0, 30);
    // Continuous request: second frame starts right after a single idle cycle
    send_frame("b2b_a", 8'h45, 1'b0, 1'b0, 6'd2, 2, 10, 11'b0_1_01000101_0, 1'b1, -1);
    send_frame("b2b_b", 8'hAA, 1'b0, 1'b0, 6'd2, 2, 10, 11'b0_1_10101010_0, 1'b0, -1);
    // Prescale 0 and 1 both give one cycle per bit
    send_frame("ps0", 8'h45, 1'b0, 1'b0, 6'd0, 1, 10, 11'b0_1_01000101_0, 1'b0, -1);
    send_frame("ps1", 8'hAA, 1'b0, 1'b0, 6'd1, 1, 10, 11'b0_1_10101010_0, 1'b0, -1);

    // Reset during data bit 3 (line low for 0x45) aborts immediately
    @(negedge clk);
    bus.P_DATA     = 8'h45;
    bus.PAR_EN     = 1'b0;
    bus.Prescale   = 6'd1;
    bus.DATA_VALID = 1'b1;
    @(posedge clk); #1;
    bus.DATA_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("pre_abort_tx", 32'(bus.TX_OUT), 0);
    rst = 1'b0;
    #1;
    check("abort_tx", 32'(bus.TX_OUT), 1);
    check("abort_busy", 32'(bus.busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_frame("after_abort", 8'h45, 1'b0, 1'b0, 6'd1, 1, 10, 11'b0_1_01000101_0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial UART transmitter. It is the transmit-side counterpart of the UART_RX receiver.
- Accepts one parallel byte per handshake and serialises it LSB-first as: start bit, data bits, optional parity bit, stop bit.
- Each bit is held on TX_OUT for Prescale clock cycles. The bit timing and parity options match what UART_RX expects, so TX_OUT can drive RX_IN directly in loopback benches.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of the Prescale input.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  byte to transmit; sampled on the accept edge.
- DATA_VALID  input  1  request to send P_DATA.
- PAR_EN  input  1  1 = append a parity bit; sampled on the accept edge.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on the accept edge.
- Prescale  input  PRESCALE_WIDTH  clock cycles per bit; sampled on the accept edge.
- TX_OUT  output  1  serial line; idle level 1.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst low, asynchronous):
  - TX_OUT=1, busy=0, state=IDLE.
  - Bit counter, cycle counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately. The line returns high with no partial stop bit.
- Accept:
  - A frame is accepted on a rising edge where state==IDLE and DATA_VALID==1.
  - On that edge, P_DATA, PAR_EN, PAR_TYP and Prescale are latched.
  - DATA_VALID while busy is ignored. There is no queueing.
- Effective bit period Teff: Prescale, with values 0 and 1 both treated as 1 cycle per bit.
- State machine: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
  - START: TX_OUT=0 for Teff cycles.
  - DATA: DATA_WIDTH bits, LSB first. Each bit is held Teff cycles and the shift register shifts right at each bit boundary.
  - PARITY: TX_OUT = ^data when PAR_TYP=0 (even), ~^data when PAR_TYP=1 (odd). Computed from the latched data, held Teff cycles.
  - STOP: TX_OUT=1 for Teff cycles, then IDLE.
- Timing and latency:
  - TX_OUT and busy are registered.
  - The start bit appears on the cycle after the accept edge. busy rises on that same cycle.
  - Frame length is (DATA_WIDTH+2)*Teff cycles without parity and (DATA_WIDTH+3)*Teff cycles with parity.
  - busy falls on the edge that ends the stop bit. The state is then IDLE.
  - The earliest next accept is that same following edge if DATA_VALID is high. This gives one IDLE cycle, with the line high, between back-to-back frames.
- Cycle counter:
  - Counts 0..Teff-1 and wraps to 0 at each bit boundary.
  - The bit counter increments only at the wrap.
  - The counter is wide enough for the maximum Prescale (63).
- Input changes while busy: changes on P_DATA, PAR_EN, PAR_TYP or Prescale have no effect on the frame in progress.

Decomposition:
- Package uart_pkg:
  - State enum for the states above.
  - Constants PAR_EVEN=1'b0, PAR_ODD=1'b1, UART_IDLE_LEVEL=1'b1.
- Sub-module uart_tx_bit_timer:
  - Inputs: Prescale latch, start and enable.
  - Output: a bit_done pulse every Teff cycles.
  - The FSM, shift register and parity logic stay in uart_tx_frame.

Test Plan:
1. Reset: hold rst=0 with DATA_VALID=1 -> TX_OUT=1 and busy=0 throughout. After release with DATA_VALID=0, the line stays high.
2. Prescale=8, PAR_EN=0, P_DATA=8'h45 -> starting the cycle after accept, the line carries 0,1,0,1,0,0,0,1,0,1, each bit held 8 cycles. busy is high for exactly 80 cycles. A UART_RX loopback yields P_DATA=8'h45 with data_valid.
3. Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=8'hAA -> parity bit is 0 and the frame is 88 cycles. Repeat with PAR_TYP=1, P_DATA=8'hA8 -> parity bit is 0.
4. Prescale=8, P_DATA=8'h01, PAR_TYP=1 -> parity bit is 0. With PAR_TYP=0 -> parity bit is 1.
5. Busy rules:
   - Pulse DATA_VALID with P_DATA=8'h3C mid-frame of an 8'h45 transfer -> it is ignored and only 8'h45 is sent.
   - Hold DATA_VALID high continuously -> back-to-back frames separated by exactly 1 idle-high cycle.
6. Prescale=0 and Prescale=1 -> each bit lasts 1 cycle and the frame is 10 cycles. Assert rst=0 during bit 3 -> TX_OUT=1 and busy=0 in the same cycle, and the next accepted frame is correct.
